sw_debounce: RTL and testbench

//  Conditions the eight raw slide-switch pins before they reach the switch PIO's
//  in_port. Per bit it provides:
//   - a 2-FF synchronizer;
//   - a stability counter that debounces the level;
//   - one-cycle rise/fall pulses.
//  sw_clean drives the PIO in_port directly. Pulses are available to other fabric

---
 rtl/sw_debounce.sv | 68 ++++++
 tb/tb_sw_debounce.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-FF synchronizer, stability-count debouncer,
// and registered one-cycle rise/fall pulses with a combined change flag.
module sw_debounce #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]               sync1;
    logic [WIDTH-1:0]               sync2;
    logic [WIDTH-1:0][CNT_BITS-1:0] cnt;

    logic [WIDTH-1:0]               clean_nxt;
    logic [WIDTH-1:0]               rise_nxt;
    logic [WIDTH-1:0]               fall_nxt;
    logic [WIDTH-1:0][CNT_BITS-1:0] cnt_nxt;

    always_comb begin
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        cnt_nxt   = cnt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] == sw_clean[i]) begin
                // Any return to the current clean level restarts qualification.
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                clean_nxt[i] = sync2[i];
                cnt_nxt[i]   = '0;
                rise_nxt[i]  = sync2[i];
                fall_nxt[i]  = ~sync2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            cnt        <= '0;
            sw_clean   <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            cnt        <= cnt_nxt;
            sw_clean   <= clean_nxt;
            sw_rise    <= rise_nxt;
            sw_fall    <= fall_nxt;
            sw_changed <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4: latency, glitch rejection,
// multi-bit pulses and mid-count reset.
module tb_sw_debounce;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    int n_assert = 0;
    int n_fail   = 0;

    sw_debounce #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(4),
        .CNT_BITS     (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] clean,
                             input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall,
                             input logic chg);
        check({tag, ".clean"}, sw_clean, clean);
        check({tag, ".rise"}, sw_rise, rise);
        check({tag, ".fall"}, sw_fall, fall);
        check({tag, ".changed"}, {7'd0, sw_changed}, {7'd0, chg});
    endtask

    initial begin
        // 1: reset with pins high, then qualify 8'hFF
        reset_n = 1'b0;
        sw_raw  = 8'hFF;
        tick(3);
        check_all("t1_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        tick(5);
        check_all("t1_e4", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t1_e5", 8'hFF, 8'hFF, 8'h00, 1'b1);
        tick(1);
        check_all("t1_e6", 8'hFF, 8'h00, 8'h00, 1'b0);

        sw_raw = 8'h00;
        tick(6);
        check_all("t1_back0", 8'h00, 8'h00, 8'hFF, 1'b1);
        tick(1);

        // 2: 3-cycle glitch on bit0 must be rejected
        sw_raw = 8'h01;
        tick(3);
        sw_raw = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_all("t2_glitch", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        // counter cleared: a held level needs the full latency again
        sw_raw = 8'h01;
        tick(5);
        check_all("t2_e4", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t2_e5", 8'h01, 8'h01, 8'h00, 1'b1);
        sw_raw = 8'h00;
        tick(6);
        check_all("t2_back0", 8'h00, 8'h00, 8'h01, 1'b1);
        tick(1);

        // 3: bit3 bounces then settles high from edge L
        sw_raw = 8'h08; tick(1);
        check_all("t3_b1", 8'h00, 8'h00, 8'h00, 1'b0);
        sw_raw = 8'h00; tick(2);
        check_all("t3_b2", 8'h00, 8'h00, 8'h00, 1'b0);
        sw_raw = 8'h08; tick(2);
        check_all("t3_b3", 8'h00, 8'h00, 8'h00, 1'b0);
        sw_raw = 8'h00; tick(1);
        check_all("t3_b4", 8'h00, 8'h00, 8'h00, 1'b0);
        sw_raw = 8'h08;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check_all("t3_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick(1);
        check_all("t3_l5", 8'h08, 8'h08, 8'h00, 1'b1);
        tick(1);
        check_all("t3_l6", 8'h08, 8'h00, 8'h00, 1'b0);

        // 4: reach 8'hA5, then everything falls together
        sw_raw = 8'hA5;
        tick(6);
        check_all("t4_toA5", 8'hA5, 8'hA5, 8'h08, 1'b1);
        tick(1);
        sw_raw = 8'h00;
        tick(5);
        check_all("t4_e4", 8'hA5, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t4_e5", 8'h00, 8'h00, 8'hA5, 1'b1);
        tick(1);
        check_all("t4_e6", 8'h00, 8'h00, 8'h00, 1'b0);

        // 5: bit0 rises and bit7 falls on the same edge
        sw_raw = 8'h80;
        tick(6);
        check_all("t5_to80", 8'h80, 8'h80, 8'h00, 1'b1);
        tick(1);
        sw_raw = 8'h01;
        tick(5);
        check_all("t5_e4", 8'h80, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t5_e5", 8'h01, 8'h01, 8'h80, 1'b1);
        tick(1);
        check_all("t5_e6", 8'h01, 8'h00, 8'h00, 1'b0);

        // 6: reset while cnt[2]==2; held-high bits requalify from zero
        sw_raw = 8'h05;
        tick(4);
        check_all("t6_precnt", 8'h01, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        check_all("t6_async", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("t6_inrst", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check_all("t6_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick(1);
        check_all("t6_e5", 8'h05, 8'h05, 8'h00, 1'b1);
        tick(1);
        check_all("t6_e6", 8'h05, 8'h00, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
